// File: rtl/servo_pkg.sv
// Shared constants and types for the servo pulse generator and its helpers.
package servo_pkg;

  localparam int SERVO_PERIOD_US = 20000;
  localparam int SERVO_MIN_US    = 1000;
  localparam int SERVO_MAX_US    = 2000;
  localparam int SERVO_CENTER_US = (SERVO_MIN_US + SERVO_MAX_US) / 2;
  localparam int WIDTH_W         = 12;

  typedef enum logic {IDLE, RUN} servo_state_t;

endpackage

// File: rtl/rise_detect.sv
// One-cycle pulse on each rising edge of a same-domain level input (e.g. divider output).
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/servo_pwm.sv
// Frame-based hobby-servo PWM: 1 us ticks from the clock divider, commands via valid/ready,
// pulse width only ever changes on a frame boundary, with optional per-frame slew limit.
module servo_pwm
  import servo_pkg::*;
#(
  parameter int PERIOD_US = SERVO_PERIOD_US,
  parameter int MIN_US    = SERVO_MIN_US,
  parameter int MAX_US    = SERVO_MAX_US,
  parameter int POS_W     = 8,
  parameter int SLEW_US   = 0
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               tick_clk,
  input  logic               enable,
  input  logic [POS_W-1:0]   pos_data,
  input  logic               pos_valid,
  output logic               pos_ready,
  output logic               pwm_out,
  output logic               frame_start,
  output logic [WIDTH_W-1:0] width_us,
  output servo_state_t       state_dbg
);

  localparam int CNT_W   = $clog2(PERIOD_US);
  localparam int PROD_W  = POS_W + 11;
  localparam int SPAN    = MAX_US - MIN_US;
  localparam int POS_MAX = (1 << POS_W) - 1;
  localparam logic [WIDTH_W-1:0] CENTER = WIDTH_W'((MIN_US + MAX_US) / 2);
  localparam logic [WIDTH_W-1:0] SLEW   = WIDTH_W'(SLEW_US);

  // Handshake: a command transfers on any clock where pos_valid && pos_ready;
  // pos_ready stays low from the cycle after a transfer until the target is fully applied.

  logic                 tick;
  servo_state_t         state, state_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [WIDTH_W-1:0]   width_cur, width_nxt, width_step, target, target_map;
  logic                 pending, pending_nxt, boundary, accept;
  logic [PROD_W-1:0]    prod;

  rise_detect u_tick (
    .clk   (clk_in),
    .rst   (rst),
    .d     (tick_clk),
    .pulse (tick)
  );

  // Full-width product so the floor is taken only once, after the divide.
  assign prod       = PROD_W'(pos_data) * PROD_W'(SPAN);
  assign target_map = WIDTH_W'(MIN_US) + WIDTH_W'(prod / PROD_W'(POS_MAX));
  assign accept     = pos_valid && !pending;

  always_comb begin
    width_step = target;
    if (SLEW_US != 0) begin
      if (target > width_cur && (target - width_cur) > SLEW)
        width_step = width_cur + SLEW;
      else if (width_cur > target && (width_cur - target) > SLEW)
        width_step = width_cur - SLEW;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    boundary  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && tick) begin
          state_nxt = RUN;
          count_nxt = '0;
          boundary  = 1'b1;
        end
      end
      RUN: begin
        // Disable takes priority over a coinciding frame boundary.
        if (!enable) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (tick) begin
          if (count == CNT_W'(PERIOD_US - 1)) begin
            count_nxt = '0;
            boundary  = 1'b1;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_comb begin
    width_nxt   = width_cur;
    pending_nxt = pending;
    if (boundary && pending) begin
      width_nxt   = width_step;
      pending_nxt = (width_step != target);
    end else if (accept) begin
      pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      width_cur   <= CENTER;
      target      <= CENTER;
      pending     <= 1'b0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      width_cur   <= width_nxt;
      pending     <= pending_nxt;
      if (accept) target <= target_map;
      pwm_out     <= (state_nxt == RUN) && (32'(count_nxt) < 32'(width_nxt));
      frame_start <= boundary;
    end
  end

  assign pos_ready = !pending;
  assign width_us  = width_cur;
  assign state_dbg = state;

endmodule

// File: tb/tb_servo_pwm.sv
// Bench for servo_pwm: two instances (no slew / 100 us slew) share timebase and enable;
// per-frame widths come from an expected queue filled when commands are accepted.
module tb_servo_pwm;
  import servo_pkg::*;

  localparam int PERIOD    = 2100;
  localparam int MIN       = 1000;
  localparam int MAX       = 2000;
  localparam int TC        = 2;
  localparam int FRAME_CYC = PERIOD * TC;
  localparam int BUDGET    = 2 * FRAME_CYC + 100;

  logic         clk_in   = 1'b0;
  logic         tick_clk = 1'b0;
  logic         rst      = 1'b1;
  logic         enable   = 1'b0;
  logic         pos_valid   [2];
  logic [7:0]   pos_data    [2];
  logic         pos_ready   [2];
  logic         pwm_out     [2];
  logic         frame_start [2];
  logic [11:0]  width_us    [2];
  servo_state_t state_dbg   [2];

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q [2][$];
  int cur_w [2];
  int last_w [2];
  int hi_cnt [2];
  int fr_cnt [2];
  bit meas_ok [2];

  always #5 clk_in = ~clk_in;
  always #10 tick_clk = ~tick_clk;

  servo_pwm #(.PERIOD_US(PERIOD), .MIN_US(MIN), .MAX_US(MAX), .POS_W(8), .SLEW_US(0)) dut_fast (
    .clk_in(clk_in), .rst(rst), .tick_clk(tick_clk), .enable(enable),
    .pos_data(pos_data[0]), .pos_valid(pos_valid[0]), .pos_ready(pos_ready[0]),
    .pwm_out(pwm_out[0]), .frame_start(frame_start[0]), .width_us(width_us[0]),
    .state_dbg(state_dbg[0])
  );

  servo_pwm #(.PERIOD_US(PERIOD), .MIN_US(MIN), .MAX_US(MAX), .POS_W(8), .SLEW_US(100)) dut_slew (
    .clk_in(clk_in), .rst(rst), .tick_clk(tick_clk), .enable(enable),
    .pos_data(pos_data[1]), .pos_valid(pos_valid[1]), .pos_ready(pos_ready[1]),
    .pwm_out(pwm_out[1]), .frame_start(frame_start[1]), .width_us(width_us[1]),
    .state_dbg(state_dbg[1])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_expect(input int i, input logic [7:0] p);
    int t;
    int step;
    t = MIN + (int'(p) * (MAX - MIN)) / 255;
    step = (i == 0) ? 0 : 100;
    if (step == 0) begin
      exp_q[i].push_back(12'(t));
      last_w[i] = t;
    end else begin
      while (last_w[i] != t) begin
        if (t > last_w[i]) last_w[i] += (t - last_w[i] > step) ? step : (t - last_w[i]);
        else               last_w[i] -= (last_w[i] - t > step) ? step : (last_w[i] - t);
        exp_q[i].push_back(12'(last_w[i]));
      end
    end
  endtask

  task automatic send_cmd(input int i, input logic [7:0] p);
    int n;
    n = 0;
    @(negedge clk_in);
    pos_data[i]  = p;
    pos_valid[i] = 1'b1;
    while (pos_ready[i] !== 1'b1 && n < BUDGET) begin
      @(negedge clk_in);
      n++;
    end
    check($sformatf("cmd_ready%0d", i), pos_ready[i], 1);
    @(posedge clk_in);
    #1;
    pos_valid[i] = 1'b0;
    push_expect(i, p);
    @(negedge clk_in);
    check($sformatf("ready_drop%0d", i), pos_ready[i], 0);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk_in);
    while (frame_start[0] !== 1'b1 && n < BUDGET) begin
      @(negedge clk_in);
      n++;
    end
    check("frame_seen", frame_start[0], 1);
  endtask

  // Second command is held on the bus while the first is still being applied.
  task automatic b2b();
    int n;
    n = 0;
    @(negedge clk_in);
    check("b2b_ready_a", pos_ready[0], 1);
    pos_data[0]  = 8'd64;
    pos_valid[0] = 1'b1;
    @(posedge clk_in);
    #1;
    pos_data[0] = 8'd200;
    push_expect(0, 8'd64);
    @(negedge clk_in);
    check("b2b_held_off", pos_ready[0], 0);
    while (pos_ready[0] !== 1'b1 && n < BUDGET) begin
      @(negedge clk_in);
      n++;
    end
    check("b2b_ready_rise", pos_ready[0], 1);
    check("b2b_at_boundary", frame_start[0], 1);
    @(posedge clk_in);
    #1;
    pos_valid[0] = 1'b0;
    push_expect(0, 8'd200);
    @(negedge clk_in);
    check("b2b_ready_drop", pos_ready[0], 0);
  endtask

  // Frame monitor: pulse/period of the finished frame, then width and ready of the new one.
  always @(negedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      if (frame_start[i] === 1'b1) begin
        if (meas_ok[i]) begin
          check($sformatf("frame_len%0d", i), fr_cnt[i], FRAME_CYC);
          check($sformatf("pulse_len%0d", i), hi_cnt[i], cur_w[i] * TC);
        end
        if (exp_q[i].size() > 0) cur_w[i] = int'(exp_q[i].pop_front());
        check($sformatf("width%0d", i), width_us[i], cur_w[i]);
        check($sformatf("ready_at_frame%0d", i), pos_ready[i], exp_q[i].size() == 0);
        meas_ok[i] = 1'b1;
        hi_cnt[i]  = 0;
        fr_cnt[i]  = 0;
      end
      if (rst || !enable) meas_ok[i] = 1'b0;
      hi_cnt[i] += (pwm_out[i] === 1'b1) ? 1 : 0;
      fr_cnt[i]++;
    end
  end

  initial begin
    bit fs_seen;
    for (int i = 0; i < 2; i++) begin
      pos_valid[i] = 1'b0;
      pos_data[i]  = 8'd0;
      cur_w[i]     = 1500;
      last_w[i]    = 1500;
      meas_ok[i]   = 1'b0;
      hi_cnt[i]    = 0;
      fr_cnt[i]    = 0;
    end
    repeat (4) @(negedge clk_in);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_pwm%0d", i), pwm_out[i], 0);
      check($sformatf("rst_fs%0d", i), frame_start[i], 0);
      check($sformatf("rst_ready%0d", i), pos_ready[i], 1);
      check($sformatf("rst_width%0d", i), width_us[i], 1500);
      check($sformatf("rst_state%0d", i), state_dbg[i], IDLE);
    end
    rst    = 1'b0;
    enable = 1'b1;

    wait_frame();
    check("state_run", state_dbg[0], RUN);
    wait_frame();
    fork
      send_cmd(0, 8'd0);
      send_cmd(1, 8'd255);
    join
    wait_frame();
    send_cmd(0, 8'd255);
    wait_frame();
    send_cmd(0, 8'd128);
    wait_frame();
    b2b();
    wait_frame();

    // Drop enable at count 700, inside both pulses.
    repeat (700 * TC) @(negedge clk_in);
    check("pwm_before_dis0", pwm_out[0], 1);
    check("pwm_before_dis1", pwm_out[1], 1);
    enable = 1'b0;
    @(negedge clk_in);
    check("pwm_dis0", pwm_out[0], 0);
    check("pwm_dis1", pwm_out[1], 0);
    check("width_dis0", width_us[0], 1784);
    check("width_dis1", width_us[1], 2000);
    fs_seen = 1'b0;
    repeat (20) begin
      @(negedge clk_in);
      fs_seen |= frame_start[0];
    end
    check("no_frame_idle", fs_seen, 0);
    check("state_idle", state_dbg[0], IDLE);
    enable = 1'b1;
    wait_frame();
    wait_frame();

    // Reset mid-pulse with a command pending and pos_valid held through reset.
    send_cmd(0, 8'd0);
    repeat (200) @(negedge clk_in);
    check("pwm_pre_rst", pwm_out[0], 1);
    rst          = 1'b1;
    pos_data[0]  = 8'd255;
    pos_valid[0] = 1'b1;
    @(negedge clk_in);
    check("rst_mid_pwm0", pwm_out[0], 0);
    check("rst_mid_pwm1", pwm_out[1], 0);
    check("rst_mid_ready", pos_ready[0], 1);
    check("rst_mid_width0", width_us[0], 1500);
    check("rst_mid_width1", width_us[1], 1500);
    @(negedge clk_in);
    check("rst_vs_valid", pos_ready[0], 1);
    rst          = 1'b0;
    pos_valid[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      cur_w[i]  = 1500;
      last_w[i] = 1500;
    end
    wait_frame();
    wait_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/servo_pwm.md
# servo_pwm

Frame-based servo PWM generator that sits directly downstream of the system clock divider. It consumes the divider's square-wave output as a 1 µs timebase and accepts position commands over a valid/ready handshake. It drives a standard 50 Hz hobby-servo pulse (1000–2000 µs), with glitch-free frame-boundary updates and optional per-frame slew limiting.

## Interface
- PERIOD_US, 20000, frame length in ticks (µs)
- MIN_US, 1000, pulse width for position 0
- MAX_US, 2000, pulse width for position 2^POS_W−1
- POS_W, 8, position command width
- SLEW_US, 0, max change of applied width per frame in µs; 0 = unlimited
- clk_in  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- tick_clk  input  1  divider output, 1 MHz square wave, same clock domain as clk_in
- enable  input  1  1 = generate frames, 0 = output held low
- pos_data  input  POS_W  commanded position
- pos_valid  input  1  pos_data valid
- pos_ready  output  1  block can accept a command
- pwm_out  output  1  servo pulse, registered
- frame_start  output  1  one-cycle pulse on the first tick of each frame
- width_us  output  12  pulse width currently being applied

## Operation
- Tick: a rising edge on tick_clk (registered previous value 0, current 1) produces an internal one-cycle `tick`. All counting advances only on `tick`.
- Mapping on accept: target = MIN_US + floor(pos_data·(MAX_US−MIN_US)/(2^POS_W−1)). Compute the product at full width (POS_W+11 bits) with no truncation before the divide.
- Handshake: pos_ready = !pending. A transfer occurs when pos_valid && pos_ready. The transfer loads the target register and sets pending. Commands are never dropped; the producer stalls while pending = 1.
- States:
  - IDLE: pwm_out = 0, count = 0. Go to RUN on the first tick with enable = 1.
  - RUN: count runs 0..PERIOD_US−1 and wraps to 0. pwm_out = (count < width_cur).
  - RUN→IDLE: when enable = 0, in the next cycle, regardless of tick.
- Frame boundary (tick with count = 0, including the first tick after entering RUN):
  - frame_start pulses.
  - If pending: width_cur moves toward target, by at most SLEW_US when SLEW_US ≠ 0, else all the way. pending clears only when width_cur = target after the update.
  - width_cur never changes mid-frame.
- Slew: step = min(|target − width_cur|, SLEW_US); no overshoot.
- A new command cannot arrive while pending = 1. Once pending clears, a new target takes effect from the next frame boundary.
- Disable mid-pulse: pwm_out falls on the next clock. The truncated pulse is acceptable. width_cur, target and pending are retained.

## Timing
- Reset values:
  - outputs: pwm_out 0, frame_start 0, pos_ready 1, width_us (MIN_US+MAX_US)/2 = 1500
  - internal: target 1500, pending 0, count 0, state IDLE, tick_clk history 0
- Latency from tick_clk rising to count update: 1 clk_in cycle.
- pwm_out and frame_start are registered, and assert in the same cycle as count becomes 0.
- pos_ready deasserts the cycle after an accepted transfer.
- Reset mid-frame drops pwm_out and returns to reset values on the next clk_in edge. A pending command is discarded.
- Simultaneous rst and pos_valid: rst wins and nothing is accepted.
- Simultaneous enable fall and frame boundary: disable wins and no frame_start is generated.

## Structure
- Package servo_pkg holds:
  - default constants: SERVO_PERIOD_US, SERVO_MIN_US, SERVO_MAX_US, SERVO_CENTER_US, WIDTH_W = 12
  - state enum servo_state_t {IDLE, RUN}
- Sub-module rise_detect (clk, rst, d, pulse) provides tick generation. It is reusable by other consumers of the divider.
- The mapping multiply/divide uses constants only and is combinational, registered into target on accept.

## Test plan
- Reset, enable = 1, no command, tick_clk at 1 MHz → frame_start every 20000 ticks; pwm_out high for exactly 1500 ticks per frame.
- Command pos = 0, then 255, then 128 (SLEW_US = 0) → widths 1000, 2000, 1501 µs. Each applies from the next frame boundary, never mid-frame.
- SLEW_US = 100, width 1500, command pos = 255 → widths 1600, 1700, 1800, 1900, 2000 over 5 frames. pos_ready stays low until the 2000 frame starts.
- Hold pos_valid with back-to-back values while pending → only the first value is accepted; the second transfers the cycle after pos_ready rises.
- enable drops at count = 700 with width 1500 → pwm_out low the next cycle. Re-enable → new frame from count 0 with frame_start; width retained.
- rst asserted mid-pulse with a command pending → pwm_out 0 next cycle, pos_ready 1, width_us 1500.
